// File: rtl/snake_pkg.sv
// Shared types, grid constants and helpers for the snake body datapath.
package snake_pkg;

    localparam int unsigned GRID     = 8;
    localparam int unsigned MAX_LEN  = 64;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned LEN_W    = 7;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned INIT_LEN = 3;
    localparam int unsigned INIT_X   = 4;
    localparam int unsigned INIT_Y   = 4;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DEAD  = 2'd3
    } state_t;

    typedef logic [COORD_W-1:0]               coord_t;
    typedef logic [MAX_LEN-1:0][COORD_W-1:0]  coord_arr_t;

    typedef struct packed {
        coord_t c;
        coord_t r;
    } cell_t;

    // Reverse direction differs only in the upper encoding bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(2'(d) ^ 2'd2);
    endfunction

    function automatic coord_arr_t init_col();
        coord_arr_t a;
        a = '0;
        for (int unsigned i = 0; i < INIT_LEN; i++) a[i] = COORD_W'(INIT_X - i);
        return a;
    endfunction

    function automatic coord_arr_t init_row();
        coord_arr_t a;
        a = '0;
        for (int unsigned i = 0; i < INIT_LEN; i++) a[i] = COORD_W'(INIT_Y);
        return a;
    endfunction

endpackage

// File: rtl/snake_if.sv
// Control and segment-array bundle between the game controller and snake_body.
interface snake_if;
    import snake_pkg::*;

    logic             step;
    dir_t             dir;
    logic             grow;
    logic             restart;
    coord_arr_t       col;
    coord_arr_t       row;
    logic [LEN_W-1:0] length;
    dir_t             cur_dir;
    logic             busy;
    logic             moved;
    logic             alive;

    modport master (
        output step, dir, grow, restart,
        input  col, row, length, cur_dir, busy, moved, alive
    );

    modport slave (
        input  step, dir, grow, restart,
        output col, row, length, cur_dir, busy, moved, alive
    );

endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head computation with toroidal wrap on the 1..GRID grid.
module snake_next_head
    import snake_pkg::*;
(
    input  cell_t head,
    input  dir_t  dir,
    output cell_t nh_c
);

    always_comb begin
        nh_c = head;
        case (dir)
            UP:    nh_c.r = (head.r == COORD_W'(1))    ? COORD_W'(GRID) : head.r - COORD_W'(1);
            RIGHT: nh_c.c = (head.c == COORD_W'(GRID)) ? COORD_W'(1)    : head.c + COORD_W'(1);
            DOWN:  nh_c.r = (head.r == COORD_W'(GRID)) ? COORD_W'(1)    : head.r + COORD_W'(1);
            LEFT:  nh_c.c = (head.c == COORD_W'(1))    ? COORD_W'(GRID) : head.c - COORD_W'(1);
            default: nh_c = head;
        endcase
    end

endmodule

// File: rtl/snake_body.sv
// Snake segment store: per-tick head advance, sequential self-collision scan,
// then a single-cycle parallel shift of all segment slots.
module snake_body
    import snake_pkg::*;
(
    input  logic    CLK,
    input  logic    RST_N,
    snake_if.slave  bus
);

    state_t           state, state_nxt;
    coord_arr_t       col_q, row_q;
    logic [LEN_W-1:0] len_q;
    dir_t             dir_q;
    cell_t            nh_q;
    logic [IDX_W-1:0] idx_q, lim_q;
    logic             grow_pend, grow_mv;
    logic             busy_q, moved_q, alive_q;

    dir_t             dir_eff_c;
    cell_t            nh_c;
    logic             hit_c;
    logic             grow_ok_c;
    logic [LEN_W:0]   shift_lim_c;

    // A reverse request keeps the current heading.
    assign dir_eff_c = (bus.dir == opposite(dir_q)) ? dir_q : bus.dir;

    snake_next_head u_next_head (
        .head ('{c: col_q[0], r: row_q[0]}),
        .dir  (dir_eff_c),
        .nh_c (nh_c)
    );

    assign hit_c       = (col_q[idx_q] == nh_q.c) && (row_q[idx_q] == nh_q.r);
    assign grow_ok_c   = bus.grow && (len_q != LEN_W'(MAX_LEN)) && (state != DEAD);
    assign shift_lim_c = {1'b0, len_q} + (LEN_W+1)'(grow_mv);

    // Next-state logic; restart overrides every state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.step) state_nxt = SCAN;
            SCAN:    if (hit_c) state_nxt = DEAD;
                     else if (idx_q == lim_q) state_nxt = SHIFT;
            SHIFT:   state_nxt = IDLE;
            DEAD:    state_nxt = DEAD;
            default: state_nxt = IDLE;
        endcase
        if (bus.restart) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_q     <= init_col();
            row_q     <= init_row();
            len_q     <= LEN_W'(INIT_LEN);
            dir_q     <= RIGHT;
            nh_q      <= '0;
            idx_q     <= '0;
            lim_q     <= '0;
            grow_pend <= 1'b0;
            grow_mv   <= 1'b0;
            busy_q    <= 1'b0;
            moved_q   <= 1'b0;
            alive_q   <= 1'b1;
        end else if (bus.restart) begin
            col_q     <= init_col();
            row_q     <= init_row();
            len_q     <= LEN_W'(INIT_LEN);
            dir_q     <= RIGHT;
            nh_q      <= '0;
            idx_q     <= '0;
            lim_q     <= '0;
            grow_pend <= 1'b0;
            grow_mv   <= 1'b0;
            busy_q    <= 1'b0;
            moved_q   <= 1'b0;
            alive_q   <= 1'b1;
        end else begin
            busy_q  <= (state_nxt == SCAN) || (state_nxt == SHIFT);
            alive_q <= (state_nxt != DEAD);
            moved_q <= (state == SHIFT);

            // A pulse landing on the consuming shift collapses into that grow.
            if ((state == SHIFT) && grow_mv) grow_pend <= 1'b0;
            else if (grow_ok_c)              grow_pend <= 1'b1;

            case (state)
                IDLE: if (bus.step) begin
                    dir_q   <= dir_eff_c;
                    nh_q    <= nh_c;
                    idx_q   <= IDX_W'(1);
                    lim_q   <= grow_pend ? IDX_W'(len_q) : IDX_W'(len_q - LEN_W'(1));
                    grow_mv <= grow_pend;
                end
                SCAN: idx_q <= idx_q + IDX_W'(1);
                SHIFT: begin
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        if ((LEN_W+1)'(i) < shift_lim_c) begin
                            col_q[i] <= col_q[i-1];
                            row_q[i] <= row_q[i-1];
                        end
                    end
                    col_q[0] <= nh_q.c;
                    row_q[0] <= nh_q.r;
                    if (grow_mv) len_q <= len_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.col     = col_q;
    assign bus.row     = row_q;
    assign bus.length  = len_q;
    assign bus.cur_dir = dir_q;
    assign bus.busy    = busy_q;
    assign bus.moved   = moved_q;
    assign bus.alive   = alive_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: moves, wrap, reverse, grow, collision, restart, full grid.
module tb_snake_body;
    import snake_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;
    int   bc;
    int   mc;
    int   total_mc;
    int   extra_mc;

    snake_if bus ();

    snake_body dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one step and wait (bounded) for busy to drop; bc = busy samples, mc = moved pulses.
    task automatic do_step(input dir_t d, output int b, output int m);
        bus.dir  = d;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        b = 0;
        m = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.moved) m++;
            if (!bus.busy) break;
            b++;
            tick();
        end
    endtask

    task automatic pulse_grow();
        bus.grow = 1'b1;
        tick();
        bus.grow = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    task automatic chk_init(input string tag);
        chk({tag, "_col0"}, int'(bus.col[0]), 4);
        chk({tag, "_col1"}, int'(bus.col[1]), 3);
        chk({tag, "_col2"}, int'(bus.col[2]), 2);
        chk({tag, "_col3"}, int'(bus.col[3]), 0);
        chk({tag, "_row0"}, int'(bus.row[0]), 4);
        chk({tag, "_row2"}, int'(bus.row[2]), 4);
        chk({tag, "_row3"}, int'(bus.row[3]), 0);
        chk({tag, "_len"}, int'(bus.length), 3);
        chk({tag, "_dir"}, int'(bus.cur_dir), 1);
        chk({tag, "_alive"}, int'(bus.alive), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_moved"}, int'(bus.moved), 0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        bus.step    = 1'b0;
        bus.dir     = RIGHT;
        bus.grow    = 1'b0;
        bus.restart = 1'b0;
        RST_N       = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        chk_init("reset");

        // Basic move right: 2 scan cycles + shift
        do_step(RIGHT, bc, mc);
        chk("mv_busy", bc, 3);
        chk("mv_moved", mc, 1);
        chk("mv_col0", int'(bus.col[0]), 5);
        chk("mv_col1", int'(bus.col[1]), 4);
        chk("mv_col2", int'(bus.col[2]), 3);
        chk("mv_col3", int'(bus.col[3]), 0);
        chk("mv_row0", int'(bus.row[0]), 4);
        chk("mv_row2", int'(bus.row[2]), 4);
        chk("mv_len", int'(bus.length), 3);
        tick();
        chk("mv_moved_once", int'(bus.moved), 0);

        // Reverse request ignored
        do_step(LEFT, bc, mc);
        chk("rev_col0", int'(bus.col[0]), 6);
        chk("rev_row0", int'(bus.row[0]), 4);
        chk("rev_dir", int'(bus.cur_dir), 1);

        // Column wrap 8 -> 1
        do_step(RIGHT, bc, mc);
        do_step(RIGHT, bc, mc);
        chk("wrapc_col0_8", int'(bus.col[0]), 8);
        do_step(RIGHT, bc, mc);
        chk("wrapc_col0", int'(bus.col[0]), 1);
        chk("wrapc_col1", int'(bus.col[1]), 8);
        chk("wrapc_col2", int'(bus.col[2]), 7);

        // Row wrap 1 -> 8 going up
        do_step(UP, bc, mc);
        do_step(UP, bc, mc);
        do_step(UP, bc, mc);
        chk("wrapr_row0_1", int'(bus.row[0]), 1);
        do_step(UP, bc, mc);
        chk("wrapr_row0", int'(bus.row[0]), 8);
        chk("wrapr_col0", int'(bus.col[0]), 1);
        chk("wrapr_dir", int'(bus.cur_dir), 0);

        pulse_restart();
        chk_init("restart1");

        // Step held into SCAN is ignored, not queued
        bus.dir  = RIGHT;
        bus.step = 1'b1;
        tick();
        chk("ign_busy", int'(bus.busy), 1);
        bus.dir = DOWN;
        tick();
        bus.step = 1'b0;
        mc = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.moved) mc++;
            if (!bus.busy) break;
            tick();
        end
        extra_mc = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.moved) extra_mc++;
        end
        chk("ign_moved", mc, 1);
        chk("ign_extra_moved", extra_mc, 0);
        chk("ign_busy_after", int'(bus.busy), 0);
        chk("ign_col0", int'(bus.col[0]), 5);
        chk("ign_row0", int'(bus.row[0]), 4);
        chk("ign_dir", int'(bus.cur_dir), 1);

        // Grow: tail retained, scan covers length slots
        pulse_grow();
        do_step(RIGHT, bc, mc);
        chk("grow_busy", bc, 4);
        chk("grow_len", int'(bus.length), 4);
        chk("grow_col0", int'(bus.col[0]), 6);
        chk("grow_col3", int'(bus.col[3]), 3);
        chk("grow_row3", int'(bus.row[3]), 4);
        chk("grow_col4", int'(bus.col[4]), 0);

        // Two pulses before one move collapse into one
        pulse_grow();
        tick();
        pulse_grow();
        do_step(RIGHT, bc, mc);
        chk("grow2_busy", bc, 5);
        chk("grow2_len", int'(bus.length), 5);
        chk("grow2_col4", int'(bus.col[4]), 3);
        do_step(RIGHT, bc, mc);
        chk("nogrow_busy", bc, 5);
        chk("nogrow_len", int'(bus.length), 5);
        chk("nogrow_col0", int'(bus.col[0]), 8);
        chk("nogrow_col4", int'(bus.col[4]), 4);
        chk("nogrow_col5", int'(bus.col[5]), 0);

        // Tight U into own body: (8,4) -> down -> left -> up hits slot 3
        do_step(DOWN, bc, mc);
        chk("u_down_row0", int'(bus.row[0]), 5);
        do_step(LEFT, bc, mc);
        chk("u_left_col0", int'(bus.col[0]), 7);
        do_step(UP, bc, mc);
        chk("dead_busy", bc, 3);
        chk("dead_moved", mc, 0);
        chk("dead_alive", int'(bus.alive), 0);
        chk("dead_len", int'(bus.length), 5);
        chk("dead_col0", int'(bus.col[0]), 7);
        chk("dead_row0", int'(bus.row[0]), 5);
        chk("dead_col4", int'(bus.col[4]), 6);
        chk("dead_row4", int'(bus.row[4]), 4);
        do_step(RIGHT, bc, mc);
        tick();
        chk("dead_step_busy", bc, 0);
        chk("dead_step_moved", mc, 0);
        chk("dead_step_col0", int'(bus.col[0]), 7);
        chk("dead_step_alive", int'(bus.alive), 0);

        pulse_restart();
        chk_init("restart2");
        chk("restart2_col4", int'(bus.col[4]), 0);
        chk("restart2_row4", int'(bus.row[4]), 0);

        // Grow to 64 along a Hamiltonian cycle of the torus (7 right, 1 down)
        total_mc = 0;
        for (int m = 2; m < 63; m++) begin
            pulse_grow();
            do_step((m % 8 == 7) ? DOWN : RIGHT, bc, mc);
            total_mc += mc;
            chk("fill_busy", bc, m + 2);
        end
        chk("fill_moved", total_mc, 61);
        chk("fill_len", int'(bus.length), 64);
        chk("fill_alive", int'(bus.alive), 1);
        chk("fill_col0", int'(bus.col[0]), 2);
        chk("fill_row0", int'(bus.row[0]), 3);
        chk("fill_col63", int'(bus.col[63]), 2);
        chk("fill_row63", int'(bus.row[63]), 4);

        // Grow at full length ignored; every cell occupied so the next move dies on the tail
        pulse_grow();
        do_step(DOWN, bc, mc);
        chk("full_busy", bc, 63);
        chk("full_moved", mc, 0);
        chk("full_len", int'(bus.length), 64);
        chk("full_alive", int'(bus.alive), 0);
        chk("full_col0", int'(bus.col[0]), 2);
        chk("full_row0", int'(bus.row[0]), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
